// File: rtl/tqvp_bus_pkg.sv
// Shared encodings, types and helpers for the TinyQV peripheral bus initiator.
package tqvp_bus_pkg;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SIZE_W = 2;

  localparam logic [SIZE_W-1:0] SZ_8      = 2'b00;
  localparam logic [SIZE_W-1:0] SZ_16     = 2'b01;
  localparam logic [SIZE_W-1:0] SZ_32     = 2'b10;
  localparam logic [SIZE_W-1:0] SZ_NONE   = 2'b11;
  localparam logic [SIZE_W-1:0] STRB_IDLE = 2'b11;

  typedef enum logic [1:0] {IDLE, WR, RD, RSP} state_t;

  typedef struct packed {
    logic              write;
    logic [SIZE_W-1:0] size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  // Byte-lane mask for an access size; illegal size yields no lanes.
  function automatic logic [DATA_W-1:0] size_mask(input logic [SIZE_W-1:0] size);
    case (size)
      SZ_8:    size_mask = 32'h0000_00FF;
      SZ_16:   size_mask = 32'h0000_FFFF;
      SZ_32:   size_mask = 32'hFFFF_FFFF;
      default: size_mask = 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/tqvp_bus_initiator_if.sv
// Command, response and peripheral-bus signals of the bus initiator.
interface tqvp_bus_initiator_if
  import tqvp_bus_pkg::*;
();

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [SIZE_W-1:0] cmd_size;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic [SIZE_W-1:0] data_write_n;
  logic [SIZE_W-1:0] data_read_n;
  logic [DATA_W-1:0] data_out;
  logic              data_ready;

  logic              busy;

  // Initiator side.
  modport master (
    input  cmd_valid, cmd_write, cmd_size, cmd_addr, cmd_wdata,
    input  rsp_ready, data_out, data_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output address, data_in, data_write_n, data_read_n, busy
  );

  // Command source, response sink and peripheral side.
  modport slave (
    output cmd_valid, cmd_write, cmd_size, cmd_addr, cmd_wdata,
    output rsp_ready, data_out, data_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  address, data_in, data_write_n, data_read_n, busy
  );

endinterface

// File: rtl/tqvp_bus_initiator.sv
// Single-outstanding initiator for the TinyQV peripheral register bus.
module tqvp_bus_initiator
  import tqvp_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_W           = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tqvp_bus_initiator_if.master bus
);

  state_t            r_state, w_state_nxt;
  logic              r_cmd_ready, w_cmd_ready_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic              r_rsp_err, w_rsp_err_nxt;
  logic              r_rsp_timeout, w_rsp_timeout_nxt;
  logic [ADDR_W-1:0] r_address, w_address_nxt;
  logic [DATA_W-1:0] r_data_in, w_data_in_nxt;
  logic [SIZE_W-1:0] r_wr_n, w_wr_n_nxt;
  logic [SIZE_W-1:0] r_rd_n, w_rd_n_nxt;
  logic [SIZE_W-1:0] r_size, w_size_nxt;
  logic [TO_W-1:0]   r_cnt, w_cnt_nxt;
  logic [TO_W-1:0]   w_cnt_inc;
  logic              w_to_hit;
  cmd_t              w_cmd;

  assign w_cmd.write = bus.cmd_write;
  assign w_cmd.size  = bus.cmd_size;
  assign w_cmd.addr  = bus.cmd_addr;
  assign w_cmd.wdata = bus.cmd_wdata;

  assign w_cnt_inc = r_cnt + TO_W'(1);
  assign w_to_hit  = (TIMEOUT_CYCLES != 0) && (w_cnt_inc == TO_W'(TIMEOUT_CYCLES));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt       = r_state;
    w_rsp_valid_nxt   = r_rsp_valid;
    w_rsp_rdata_nxt   = r_rsp_rdata;
    w_rsp_err_nxt     = r_rsp_err;
    w_rsp_timeout_nxt = r_rsp_timeout;
    w_address_nxt     = r_address;
    w_data_in_nxt     = r_data_in;
    w_wr_n_nxt        = r_wr_n;
    w_rd_n_nxt        = r_rd_n;
    w_size_nxt        = r_size;
    w_cnt_nxt         = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (bus.cmd_valid && r_cmd_ready) begin
          if (w_cmd.size == SZ_NONE) begin
            w_rsp_valid_nxt = 1'b1;
            w_rsp_err_nxt   = 1'b1;
            w_rsp_rdata_nxt = '0;
            w_state_nxt     = RSP;
          end else begin
            w_address_nxt = w_cmd.addr;
            w_size_nxt    = w_cmd.size;
            if (w_cmd.write) begin
              w_data_in_nxt = w_cmd.wdata & size_mask(w_cmd.size);
              w_wr_n_nxt    = w_cmd.size;
              w_state_nxt   = WR;
            end else begin
              w_rd_n_nxt  = w_cmd.size;
              w_cnt_nxt   = '0;
              w_state_nxt = RD;
            end
          end
        end
      end
      WR: begin
        w_wr_n_nxt      = STRB_IDLE;
        w_rsp_valid_nxt = 1'b1;
        w_rsp_rdata_nxt = '0;
        w_state_nxt     = RSP;
      end
      RD: begin
        // Data arriving on the timeout cycle still completes the read.
        if (bus.data_ready) begin
          w_rd_n_nxt      = STRB_IDLE;
          w_rsp_rdata_nxt = bus.data_out & size_mask(r_size);
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = RSP;
        end else if (w_to_hit) begin
          w_rd_n_nxt        = STRB_IDLE;
          w_rsp_rdata_nxt   = '0;
          w_rsp_timeout_nxt = 1'b1;
          w_rsp_valid_nxt   = 1'b1;
          w_state_nxt       = RSP;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      RSP: begin
        if (bus.rsp_ready) begin
          w_rsp_valid_nxt   = 1'b0;
          w_rsp_err_nxt     = 1'b0;
          w_rsp_timeout_nxt = 1'b0;
          w_rsp_rdata_nxt   = '0;
          w_state_nxt       = IDLE;
        end
      end
    endcase
    w_cmd_ready_nxt = (w_state_nxt == IDLE);
    w_busy_nxt      = (w_state_nxt != IDLE);
  end

  // Registered outputs and datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_ready   <= 1'b1;
      r_busy        <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_address     <= '0;
      r_data_in     <= '0;
      r_wr_n        <= STRB_IDLE;
      r_rd_n        <= STRB_IDLE;
      r_size        <= SZ_8;
      r_cnt         <= '0;
    end else begin
      r_cmd_ready   <= w_cmd_ready_nxt;
      r_busy        <= w_busy_nxt;
      r_rsp_valid   <= w_rsp_valid_nxt;
      r_rsp_rdata   <= w_rsp_rdata_nxt;
      r_rsp_err     <= w_rsp_err_nxt;
      r_rsp_timeout <= w_rsp_timeout_nxt;
      r_address     <= w_address_nxt;
      r_data_in     <= w_data_in_nxt;
      r_wr_n        <= w_wr_n_nxt;
      r_rd_n        <= w_rd_n_nxt;
      r_size        <= w_size_nxt;
      r_cnt         <= w_cnt_nxt;
    end
  end

  assign bus.cmd_ready    = r_cmd_ready;
  assign bus.busy         = r_busy;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_rdata    = r_rsp_rdata;
  assign bus.rsp_err      = r_rsp_err;
  assign bus.rsp_timeout  = r_rsp_timeout;
  assign bus.address      = r_address;
  assign bus.data_in      = r_data_in;
  assign bus.data_write_n = r_wr_n;
  assign bus.data_read_n  = r_rd_n;

endmodule

// File: tb/tb_tqvp_bus_initiator.sv
// Directed bench for tqvp_bus_initiator: vector table plus timeout and reset sequences.
module tb_tqvp_bus_initiator;
  import tqvp_bus_pkg::*;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  tqvp_bus_initiator_if bus ();
  tqvp_bus_initiator_if bus_to ();

  tqvp_bus_initiator u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  tqvp_bus_initiator #(
    .TIMEOUT_CYCLES (4),
    .TO_W           (3)
  ) u_dut_to (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_to)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [31:0] dout;
    int          delay;
    int          hold;
    logic [31:0] exp_din;
    int          exp_strb;
    int          exp_lat;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One command through the main DUT with a simple peripheral model.
  task automatic run_vec(input int idx, input vec_t v);
    int cyc;
    int sc;
    int bad;
    string p;
    p = $sformatf("v%0d", idx);
    bus.cmd_valid  = 1'b1;
    bus.cmd_write  = v.wr;
    bus.cmd_size   = v.size;
    bus.cmd_addr   = v.addr;
    bus.cmd_wdata  = v.wdata;
    bus.data_out   = v.dout;
    bus.data_ready = 1'b0;
    bus.rsp_ready  = 1'b0;
    check({p, "_cmd_ready_idle"}, 32'(bus.cmd_ready), 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
    cyc = 1;
    sc  = 0;
    bad = 0;
    while (!bus.rsp_valid && cyc < 40) begin
      if (bus.data_write_n != 2'b11 || bus.data_read_n != 2'b11) begin
        sc++;
        if ((v.wr ? bus.data_write_n : bus.data_read_n) != v.size) bad++;
        if ((v.wr ? bus.data_read_n : bus.data_write_n) != 2'b11) bad++;
        if (bus.address != v.addr) bad++;
        if (v.wr && bus.data_in != v.exp_din) bad++;
        if (bus.cmd_ready !== 1'b0 || bus.busy !== 1'b1) bad++;
      end
      bus.data_ready = (sc > v.delay);
      tick();
      cyc++;
    end
    bus.data_ready = 1'b0;
    check({p, "_strobe_bus"}, 32'(bad), 32'd0);
    check({p, "_strobe_cycles"}, 32'(sc), 32'(v.exp_strb));
    check({p, "_rsp_latency"}, 32'(cyc), 32'(v.exp_lat));
    check({p, "_rdata"}, bus.rsp_rdata, v.exp_rdata);
    check({p, "_err"}, 32'(bus.rsp_err), 32'(v.exp_err));
    check({p, "_timeout"}, 32'(bus.rsp_timeout), 32'd0);
    check({p, "_busy_rsp"}, 32'({bus.busy, bus.cmd_ready}), 32'b10);
    check({p, "_strobes_idle"}, 32'({bus.data_write_n, bus.data_read_n}), 32'hF);
    bad = 0;
    for (int i = 0; i < v.hold; i++) begin
      tick();
      if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== v.exp_err || bus.rsp_rdata !== v.exp_rdata ||
          bus.cmd_ready !== 1'b0 || bus.data_write_n !== 2'b11 || bus.data_read_n !== 2'b11) bad++;
    end
    if (v.hold > 0) check({p, "_hold_stable"}, 32'(bad), 32'd0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check({p, "_after_rsp"}, 32'({bus.rsp_valid, bus.rsp_err, bus.cmd_ready, bus.busy}), 32'b0010);
    if (!v.exp_err) check({p, "_addr_hold"}, 32'(bus.address), 32'(v.addr));
  endtask

  // 16-bit read on the short-timeout DUT; data_ready rises after 'delay' strobe cycles.
  task automatic run_to(input string p, input int delay, input int exp_strb, input int exp_lat,
                        input logic exp_to, input logic [31:0] exp_rdata);
    int cyc;
    int sc;
    bus_to.cmd_valid  = 1'b1;
    bus_to.cmd_write  = 1'b0;
    bus_to.cmd_size   = SZ_16;
    bus_to.cmd_addr   = 6'h0A;
    bus_to.data_out   = 32'h89AB_CDEF;
    bus_to.data_ready = 1'b0;
    bus_to.rsp_ready  = 1'b0;
    tick();
    bus_to.cmd_valid = 1'b0;
    cyc = 1;
    sc  = 0;
    while (!bus_to.rsp_valid && cyc < 40) begin
      if (bus_to.data_read_n != 2'b11) sc++;
      bus_to.data_ready = (sc > delay);
      tick();
      cyc++;
    end
    bus_to.data_ready = 1'b0;
    check({p, "_strobe_cycles"}, 32'(sc), 32'(exp_strb));
    check({p, "_rsp_latency"}, 32'(cyc), 32'(exp_lat));
    check({p, "_timeout_flag"}, 32'(bus_to.rsp_timeout), 32'(exp_to));
    check({p, "_rdata"}, bus_to.rsp_rdata, exp_rdata);
    check({p, "_rd_idle"}, 32'(bus_to.data_read_n), 32'h3);
    bus_to.rsp_ready = 1'b1;
    tick();
    bus_to.rsp_ready = 1'b0;
    check({p, "_after_rsp"}, 32'({bus_to.rsp_valid, bus_to.rsp_timeout, bus_to.cmd_ready}), 32'b001);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    vecs[0] = '{1'b1, SZ_32,   6'h28, 32'h1F00_1234, 32'h0000_0000, 0, 0,  32'h1F00_1234, 1, 2, 32'h0000_0000, 1'b0};
    vecs[1] = '{1'b0, SZ_8,    6'h18, 32'h0000_0000, 32'hDEAD_BEA5, 0, 0,  32'h0000_0000, 1, 2, 32'h0000_00A5, 1'b0};
    vecs[2] = '{1'b0, SZ_16,   6'h04, 32'h0000_0000, 32'h1234_5678, 5, 0,  32'h0000_0000, 6, 7, 32'h0000_5678, 1'b0};
    vecs[3] = '{1'b1, SZ_8,    6'h3F, 32'hAABB_CCDD, 32'h0000_0000, 0, 0,  32'h0000_00DD, 1, 2, 32'h0000_0000, 1'b0};
    vecs[4] = '{1'b1, SZ_16,   6'h01, 32'h1234_ABCD, 32'h0000_0000, 0, 0,  32'h0000_ABCD, 1, 2, 32'h0000_0000, 1'b0};
    vecs[5] = '{1'b0, SZ_32,   6'h20, 32'h0000_0000, 32'hCAFE_F00D, 2, 0,  32'h0000_0000, 3, 4, 32'hCAFE_F00D, 1'b0};
    vecs[6] = '{1'b0, SZ_NONE, 6'h10, 32'h0000_0000, 32'hFFFF_FFFF, 0, 10, 32'h0000_0000, 0, 1, 32'h0000_0000, 1'b1};
    vecs[7] = '{1'b1, SZ_NONE, 6'h11, 32'h1234_5678, 32'h0000_0000, 0, 0,  32'h0000_0000, 0, 1, 32'h0000_0000, 1'b1};

    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_size = SZ_8; bus.cmd_addr = '0;
    bus.cmd_wdata = '0; bus.rsp_ready = 1'b0; bus.data_out = '0; bus.data_ready = 1'b0;
    bus_to.cmd_valid = 1'b0; bus_to.cmd_write = 1'b0; bus_to.cmd_size = SZ_8; bus_to.cmd_addr = '0;
    bus_to.cmd_wdata = '0; bus_to.rsp_ready = 1'b0; bus_to.data_out = '0; bus_to.data_ready = 1'b0;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", 32'({bus.cmd_ready, bus.busy, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}), 32'b10000);
    check("reset_strobes", 32'({bus.data_write_n, bus.data_read_n}), 32'hF);
    check("reset_address", 32'(bus.address), 32'd0);
    check("reset_data_in", bus.data_in, 32'd0);
    check("reset_rdata", bus.rsp_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    run_to("to_never", 1000, 4, 5, 1'b1, 32'h0000_0000);
    run_to("to_tie",   3,    4, 5, 1'b0, 32'h0000_CDEF);
    run_to("to_early", 2,    3, 4, 1'b0, 32'h0000_CDEF);

    // Reset asserted in the middle of a held read strobe.
    bus.cmd_valid  = 1'b1;
    bus.cmd_write  = 1'b0;
    bus.cmd_size   = SZ_32;
    bus.cmd_addr   = 6'h33;
    bus.data_ready = 1'b0;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    tick();
    check("rst_mid_strobe_before", 32'({bus.data_read_n, bus.busy}), 32'b101);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_strobe_rd_n", 32'(bus.data_read_n), 32'h3);
    check("rst_mid_busy_ready", 32'({bus.busy, bus.cmd_ready, bus.rsp_valid}), 32'b010);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_vec(8, vecs[1]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
